// File: rtl/abs_value_pipe.sv
// Streaming two-stage absolute-value unit: signed sample in, unsigned magnitude out.
// Optional running-peak register on completed output transfers, enabled by ABS_PEAK_HOLD_EN.
module abs_value_pipe #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sign,
  output logic             out_ovf
`ifdef ABS_PEAK_HOLD_EN
  ,
  input  logic             peak_clr,
  output logic [WIDTH-1:0] peak_value
`endif
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  // Handshake: a transfer happens on an edge where valid && ready on that side;
  // both stages advance together, so a stalled output freezes the whole pipe.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic             s1_sign;
  logic [WIDTH-1:0] s1_neg;
  logic             s1_min;

  logic [WIDTH-1:0] s2_mag;

  always_comb begin
    s2_mag = s1_sign ? s1_neg : s1_x;
    if (s1_min) begin
      s2_mag = (SATURATE != 0) ? MAX_POS : s1_neg;
    end
  end

  // Payload registers load only with a valid sample, so idle-cycle data never reaches the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_sign   <= 1'b0;
      s1_neg    <= '0;
      s1_min    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sign  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x    <= in_data;
        s1_sign <= in_data[WIDTH-1];
        s1_neg  <= ~in_data + ONE;
        s1_min  <= (in_data == MIN_VAL);
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_mag;
        out_sign <= s1_sign;
        out_ovf  <= s1_min;
      end
    end
  end

`ifdef ABS_PEAK_HOLD_EN
  logic [WIDTH-1:0] peak_base;
  assign peak_base = peak_clr ? '0 : peak_value;

  // Clear takes effect before the compare, so a coincident transfer becomes the new peak.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_value <= '0;
    end else if (out_valid && out_ready && (out_data > peak_base)) begin
      peak_value <= out_data;
    end else begin
      peak_value <= peak_base;
    end
  end
`endif

endmodule

// File: tb/tb_abs_value_pipe.sv
// Bench for abs_value_pipe: saturating and wrapping instances driven in lockstep,
// checked through an expected-result queue. Peak checks compile in with ABS_PEAK_HOLD_EN.
`timescale 1ns/1ps
module tb_abs_value_pipe;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, out_sign, out_ovf;
  logic [W-1:0] out_data;
  logic         in_ready_w, out_valid_w, out_sign_w, out_ovf_w;
  logic [W-1:0] out_data_w;
`ifdef ABS_PEAK_HOLD_EN
  logic         peak_clr = 1'b0;
  logic [W-1:0] peak_value, peak_value_w;
`endif

  abs_value_pipe #(.WIDTH(W), .SATURATE(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sign(out_sign), .out_ovf(out_ovf)
`ifdef ABS_PEAK_HOLD_EN
    , .peak_clr(peak_clr), .peak_value(peak_value)
`endif
  );

  abs_value_pipe #(.WIDTH(W), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_sign(out_sign_w), .out_ovf(out_ovf_w)
`ifdef ABS_PEAK_HOLD_EN
    , .peak_clr(peak_clr), .peak_value(peak_value_w)
`endif
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {wrap_data[15:0], ovf, sign, sat_data[15:0]}
  localparam int EW = 2*W + 2;
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [W-1:0] x);
    logic [W-1:0] sat, wrp;
    logic sgn, ovf;
    int signed v;
    sgn = x[W-1];
    v   = int'($signed(x));
    if (v < 0) v = -v;
    wrp = v[W-1:0];
    ovf = (x == 16'h8000);
    sat = ovf ? 16'h7FFF : wrp;
    return {wrp, ovf, sgn, sat};
  endfunction

  function automatic logic [EW-1:0] actual();
    return {out_data_w, out_ovf, out_sign, out_data};
  endfunction

  // ---------------- driver ----------------
  logic accepted;

  task automatic drive_cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                             input logic [EW-1:0] exp_e);
    logic [EW-1:0] e;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got=%h expected=none", actual());
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard", actual(), e);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) exp_q.push_back(exp_e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      drive_cycle(1'b0, W'($urandom), 1'b1, '0);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got=%0d pending expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] sat;
    logic [W-1:0] wrp;
    logic         sgn;
    logic         ovf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{16'h0005, 16'h0005, 16'h0005, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFB, 16'h0005, 16'h0005, 1'b1, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    tbl[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 16'h0001, 16'h0001, 1'b1, 1'b0};
    tbl[6] = '{16'h8001, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
    tbl[7] = '{16'hFF00, 16'h0100, 16'h0100, 1'b1, 1'b0};
    tbl[8] = '{16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_outputs", {16'h0, out_ovf, out_sign, out_data}, '0);
    chk("reset_valid_ready", {out_valid, in_ready}, 2'b01);

    // Table stream at full rate: results emerge on consecutive cycles once the pipe fills
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b1, tbl[i].din, 1'b1, {tbl[i].wrp, tbl[i].ovf, tbl[i].sgn, tbl[i].sat});
      if (i < 2) chk("stream_fill", EW'(out_valid), '0);
      else       chk("stream_valid", EW'(out_valid), 1);
    end
    drain();

    // Backpressure: stall with 0100 presented
    drive_cycle(1'b1, 16'hFF00, 1'b1, model(16'hFF00));
    drive_cycle(1'b1, 16'h1234, 1'b1, model(16'h1234));
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 16'h0042, 1'b0, model(16'h0042));
      chk("stall_in_ready", EW'(in_ready), '0);
      chk("stall_hold", {out_valid, out_data}, {1'b1, 16'h0100});
    end
    drive_cycle(1'b0, 16'h0000, 1'b1, '0);
    drive_cycle(1'b0, 16'h0000, 1'b1, '0);
    chk("release_next", {out_valid, out_data}, {1'b1, 16'h1234});
    drain();

    // Reset mid-stream with both stages full
    drive_cycle(1'b1, 16'h0007, 1'b1, model(16'h0007));
    drive_cycle(1'b1, 16'hFFF7, 1'b0, model(16'hFFF7));
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("post_reset", {out_valid, in_ready}, 2'b01);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, W'($urandom), 1'b1, '0);
    chk("post_reset_idle", EW'(out_valid), '0);

    // Random stream with random in_valid/out_ready against the reference model
    begin
      int sent = 0;
      int cyc = 0;
      logic [W-1:0] x;
      while (sent < 1000 && cyc < 6000) begin
        x = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
        drive_cycle($urandom_range(0, 3) != 0, x, $urandom_range(0, 3) != 0, model(x));
        if (accepted) sent++;
        cyc++;
      end
      checks++;
      if (sent < 1000) begin
        errors++;
        $display("FAIL random_budget: got=%0d sent expected=1000", sent);
      end
      drain();
    end

`ifdef ABS_PEAK_HOLD_EN
    @(negedge clk);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    #1;
    chk("peak_clear", EW'(peak_value), '0);
    drive_cycle(1'b1, 16'h0003, 1'b1, model(16'h0003));
    drive_cycle(1'b1, 16'hFFF0, 1'b1, model(16'hFFF0));
    drive_cycle(1'b1, 16'h0008, 1'b1, model(16'h0008));
    drain();
    chk("peak_max", EW'(peak_value), EW'(16'h0010));
    drive_cycle(1'b1, 16'h0002, 1'b1, model(16'h0002));
    @(negedge clk);
    peak_clr = 1'b1;
    drive_cycle(1'b0, 16'h0000, 1'b1, '0);
    @(negedge clk);
    peak_clr = 1'b0;
    #1;
    chk("peak_clr_with_xfer", EW'(peak_value), EW'(16'h0002));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
